// File: rtl/dac_sertx_pkg.sv
// dac_sertx_pkg: shared types and helpers for the DAC serial transmitter.
// Holds the frame state encoding, the divider width and the divider clamp.
package dac_sertx_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // A divider of zero would never tick, so it behaves like a divider of one.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// sclk_tick_gen: free-running divider that emits a one-cycle tick every
// i_div clock cycles. i_restart zeroes the count so the first tick after a
// restart lands exactly i_div cycles later.
module sclk_tick_gen
  import dac_sertx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  // The tick is decoded from the count so it is high during the last cycle of
  // each period; >= keeps the counter wrapping even if i_div shrank.
  assign o_tick = (r_cnt >= (i_div - DIV_W'(1)));

  // Period counter: restart wins, otherwise wrap on tick.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dac_sertx.sv
// dac_sertx: SPI-style DAC serial transmitter. Takes one parallel sample over
// valid/ready, then drives cs low, an idle-high sclk and MSB-first data,
// followed by a one-tick hold and a two-tick gap with cs high.
// Optional: define DAC_SERTX_LDAC_EN to add the active-low dac_ldac strobe,
// pulsed during the second gap tick.
module dac_sertx
  import dac_sertx_pkg::*;
#(
  parameter int   DATA_WIDTH = 16,
  parameter logic CS_INV     = 1'b0,
  parameter logic SD_INV     = 1'b0
) (
  input  logic                  CLK100MHZ,
  input  logic                  resetn,
  input  logic [DIV_W-1:0]      dac_clk_div,
  input  logic [DATA_WIDTH-1:0] dac_data,
  input  logic                  dac_valid,
  output logic                  dac_ready,
  output logic                  dac_cs,
  output logic                  dac_sclk,
  output logic                  dac_sd,
  output logic                  dac_done
`ifdef DAC_SERTX_LDAC_EN
  ,
  output logic                  dac_ldac
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_t                r_state;
  logic                  r_cs;
  logic                  r_sclk;
  logic                  r_sd;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_gap_last;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DIV_W-1:0]      r_div;
`ifdef DAC_SERTX_LDAC_EN
  logic                  r_ldac;
`endif

  logic w_accept;
  logic w_tick;

  assign w_accept = dac_valid && r_ready;

  // Divider restarts on accept so the frame is aligned to the accept edge.
  sclk_tick_gen u_tick (
    .clk       (CLK100MHZ),
    .rst_n     (resetn),
    .i_restart (w_accept),
    .i_div     (r_div),
    .o_tick    (w_tick)
  );

  // Frame sequencer: every output is registered, so an async reset forces the
  // pins straight back to their idle levels and abandons the frame.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_cs       <= 1'b1;
      r_sclk     <= 1'b1;
      r_sd       <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_gap_last <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_div      <= DIV_W'(1);
`ifdef DAC_SERTX_LDAC_EN
      r_ldac     <= 1'b1;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= SETUP;
            r_ready   <= 1'b0;
            r_cs      <= 1'b0;
            r_sclk    <= 1'b1;
            r_sd      <= dac_data[DATA_WIDTH-1];
            r_shift   <= dac_data;
            r_div     <= clamp_div(dac_clk_div);
            r_bit_cnt <= CNT_W'(DATA_WIDTH - 1);
          end
        end
        SETUP: begin
          if (w_tick) begin
            r_state <= SHIFT;
            r_sclk  <= 1'b0;
          end
        end
        SHIFT: begin
          // sclk itself tells which half of the bit we are in.
          if (w_tick) begin
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else if (r_bit_cnt == '0) begin
              r_state <= HOLD;
            end else begin
              // Data moves with the falling edge, a full half-period before
              // the DAC samples it on the next rising edge.
              r_sclk    <= 1'b0;
              r_sd      <= r_shift[DATA_WIDTH-2];
              r_shift   <= r_shift << 1;
              r_bit_cnt <= r_bit_cnt - CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_state    <= GAP;
            r_cs       <= 1'b1;
            r_sd       <= 1'b0;
            r_done     <= 1'b1;
            r_gap_last <= 1'b0;
          end
        end
        GAP: begin
          if (w_tick) begin
            if (!r_gap_last) begin
              r_gap_last <= 1'b1;
`ifdef DAC_SERTX_LDAC_EN
              r_ldac     <= 1'b0;
`endif
            end else begin
              r_state <= IDLE;
              r_ready <= 1'b1;
`ifdef DAC_SERTX_LDAC_EN
              r_ldac  <= 1'b1;
`endif
            end
          end
        end
        // NOTE: the default arm recovers from unreachable encodings of the
        // 3-bit state instead of leaving the FSM stuck.
        default: begin
          r_state <= IDLE;
          r_cs    <= 1'b1;
          r_sclk  <= 1'b1;
          r_sd    <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign dac_ready = r_ready;
  assign dac_done  = r_done;
  assign dac_cs    = r_cs ^ CS_INV;
  assign dac_sclk  = r_sclk ^ CS_INV;
  assign dac_sd    = r_sd ^ SD_INV;
`ifdef DAC_SERTX_LDAC_EN
  assign dac_ldac  = r_ldac;
`endif

endmodule

// File: tb/tb_dac_sertx.sv
// tb_dac_sertx: directed self-checking bench for dac_sertx. A second instance
// with both inversions enabled shares all inputs so its pins can be compared
// against the plain instance cycle by cycle.
// The dac_ldac scenario is active when DAC_SERTX_LDAC_EN is defined.
module tb_dac_sertx;

  logic        clk;
  logic        resetn;
  logic [31:0] dac_clk_div;
  logic [15:0] dac_data;
  logic        dac_valid;
  logic        dac_ready, dac_cs, dac_sclk, dac_sd, dac_done;
  logic        dac_ready_i, dac_cs_i, dac_sclk_i, dac_sd_i, dac_done_i;
`ifdef DAC_SERTX_LDAC_EN
  logic        dac_ldac, dac_ldac_i;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Frame measurements filled by monitor_frame.
  int          m_cs_low, m_cs_high_tail, m_cs_rise, m_rises, m_done, m_ready_at;
  int          m_sclk_low, m_bad_spacing, m_inv_err, m_len, m_ldac_low, m_ldac_first;
  logic [31:0] m_word;
  logic [2:0]  m_wave [0:2047];
  logic [2:0]  ref_wave [0:2047];
  int          ref_len;

  dac_sertx #(.DATA_WIDTH(16), .CS_INV(1'b0), .SD_INV(1'b0)) dut (
    .CLK100MHZ   (clk),
    .resetn      (resetn),
    .dac_clk_div (dac_clk_div),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .dac_ready   (dac_ready),
    .dac_cs      (dac_cs),
    .dac_sclk    (dac_sclk),
    .dac_sd      (dac_sd),
    .dac_done    (dac_done)
`ifdef DAC_SERTX_LDAC_EN
    ,
    .dac_ldac    (dac_ldac)
`endif
  );

  dac_sertx #(.DATA_WIDTH(16), .CS_INV(1'b1), .SD_INV(1'b1)) dut_inv (
    .CLK100MHZ   (clk),
    .resetn      (resetn),
    .dac_clk_div (dac_clk_div),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .dac_ready   (dac_ready_i),
    .dac_cs      (dac_cs_i),
    .dac_sclk    (dac_sclk_i),
    .dac_sd      (dac_sd_i),
    .dac_done    (dac_done_i)
`ifdef DAC_SERTX_LDAC_EN
    ,
    .dac_ldac    (dac_ldac_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for ready, presents one sample and returns 1 time unit
  // after the accept edge. hold keeps dac_valid asserted afterwards.
  task automatic send(input logic [15:0] d, input logic [31:0] div, input bit hold);
    for (int w = 0; w < 500 && !dac_ready; w++) begin
      @(posedge clk); #1;
    end
    if (!dac_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_wait_ready: ready never rose within 500 cycles");
    end
    dac_data    = d;
    dac_clk_div = div;
    dac_valid   = 1'b1;
    @(posedge clk); #1;
    if (!hold) dac_valid = 1'b0;
  endtask

  // Called 1 time unit after an accept edge; sample k is the state after
  // edge k (k = 0 is the accept edge). Stops once ready is seen high.
  task automatic monitor_frame(input int n_eff);
    int   k;
    int   last_rise;
    logic prev_sclk, prev_cs;
    m_cs_low = 0; m_cs_high_tail = 0; m_cs_rise = -1; m_rises = 0; m_done = 0;
    m_ready_at = -1; m_sclk_low = 0; m_bad_spacing = 0; m_inv_err = 0;
    m_ldac_low = 0; m_ldac_first = -1; m_word = '0;
    prev_sclk = 1'b1; prev_cs = 1'b1; last_rise = 0;
    for (k = 0; k < 2000; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      m_wave[k] = {dac_cs, dac_sclk, dac_sd};
      if (!dac_cs) begin
        m_cs_low++;
        m_cs_high_tail = 0;
      end else begin
        m_cs_high_tail++;
        if (!prev_cs) m_cs_rise = k;
      end
      if (!dac_sclk) m_sclk_low++;
      if (dac_sclk && !prev_sclk) begin
        m_rises++;
        m_word = {m_word[30:0], dac_sd};
        if (m_rises > 1 && (k - last_rise) != 2 * n_eff) m_bad_spacing++;
        last_rise = k;
      end
      if (dac_done) m_done++;
      if ({dac_cs_i, dac_sclk_i, dac_sd_i} !== ~{dac_cs, dac_sclk, dac_sd} ||
          dac_ready_i !== dac_ready || dac_done_i !== dac_done) m_inv_err++;
`ifdef DAC_SERTX_LDAC_EN
      if (!dac_ldac) begin
        m_ldac_low++;
        if (m_ldac_first < 0) m_ldac_first = k;
      end
`endif
      prev_sclk = dac_sclk;
      prev_cs   = dac_cs;
      if (dac_ready) begin
        m_ready_at = k;
        break;
      end
    end
    m_len = k;
    if (m_ready_at < 0) begin
      n_cmp++; n_err++;
      $display("FAIL frame_timeout: ready not seen within 2000 cycles");
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; dac_valid = 1'b0; dac_data = '0; dac_clk_div = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dac_cs !== 1'b1)    begin n_err++; $display("FAIL reset_cs: got %b want 1", dac_cs); end
    n_cmp++; if (dac_sclk !== 1'b1)  begin n_err++; $display("FAIL reset_sclk: got %b want 1", dac_sclk); end
    n_cmp++; if (dac_sd !== 1'b0)    begin n_err++; $display("FAIL reset_sd: got %b want 0", dac_sd); end
    n_cmp++; if (dac_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", dac_ready); end
    n_cmp++; if (dac_done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", dac_done); end
    n_cmp++; if ({dac_cs_i, dac_sclk_i, dac_sd_i} !== 3'b001)
      begin n_err++; $display("FAIL reset_inv_pins: got %b want 001", {dac_cs_i, dac_sclk_i, dac_sd_i}); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    send(16'hA5C3, 32'd1, 1'b0);
    monitor_frame(1);
    n_cmp++; if (m_cs_low != 34)   begin n_err++; $display("FAIL basic_cs_low: got %0d want 34", m_cs_low); end
    n_cmp++; if (m_rises != 16)    begin n_err++; $display("FAIL basic_rises: got %0d want 16", m_rises); end
    n_cmp++; if (m_word !== 32'h0000A5C3) begin n_err++; $display("FAIL basic_word: got %h want 0000a5c3", m_word); end
    n_cmp++; if (m_done != 1)      begin n_err++; $display("FAIL basic_done: got %0d want 1", m_done); end
    n_cmp++; if (m_ready_at != 36) begin n_err++; $display("FAIL basic_ready_at: got %0d want 36", m_ready_at); end
    n_cmp++; if (m_sclk_low != 16) begin n_err++; $display("FAIL basic_sclk_low: got %0d want 16", m_sclk_low); end
  endtask

  task automatic test_divider();
    int diff;
    send(16'h3C96, 32'd1, 1'b0);
    monitor_frame(1);
    ref_len = m_len;
    for (int i = 0; i <= m_len; i++) ref_wave[i] = m_wave[i];
    send(16'h3C96, 32'd0, 1'b0);
    monitor_frame(1);
    diff = 0;
    for (int i = 0; i <= m_len; i++) if (m_wave[i] !== ref_wave[i]) diff++;
    n_cmp++; if (m_len != ref_len) begin n_err++; $display("FAIL div0_len: got %0d want %0d", m_len, ref_len); end
    n_cmp++; if (diff != 0)        begin n_err++; $display("FAIL div0_wave: got %0d differing cycles want 0", diff); end
    // N=5, with the divider and data inputs disturbed right after accept.
    send(16'hC35A, 32'd5, 1'b0);
    dac_clk_div = 32'd1;
    dac_data    = 16'hFFFF;
    monitor_frame(5);
    n_cmp++; if (m_ready_at != 180) begin n_err++; $display("FAIL div5_ready_at: got %0d want 180", m_ready_at); end
    n_cmp++; if (m_bad_spacing != 0) begin n_err++; $display("FAIL div5_spacing: got %0d bad periods want 0", m_bad_spacing); end
    n_cmp++; if (m_sclk_low != 80)  begin n_err++; $display("FAIL div5_sclk_low: got %0d want 80", m_sclk_low); end
    n_cmp++; if (m_cs_low != 170)   begin n_err++; $display("FAIL div5_cs_low: got %0d want 170", m_cs_low); end
    n_cmp++; if (m_word !== 32'h0000C35A) begin n_err++; $display("FAIL div5_word: got %h want 0000c35a", m_word); end
  endtask

  task automatic test_back_to_back();
    send(16'h0001, 32'd1, 1'b1);
    dac_data = 16'hFFFF;
    monitor_frame(1);
    n_cmp++; if (m_word !== 32'h00000001) begin n_err++; $display("FAIL b2b_word0: got %h want 00000001", m_word); end
    n_cmp++; if (m_ready_at != 36) begin n_err++; $display("FAIL b2b_ready_at0: got %0d want 36", m_ready_at); end
    @(posedge clk); #1;
    dac_valid = 1'b0;
    n_cmp++; if ({dac_cs, dac_ready} !== 2'b00)
      begin n_err++; $display("FAIL b2b_immediate_accept: got cs,ready=%b want 00", {dac_cs, dac_ready}); end
    n_cmp++; if (m_cs_high_tail != 3) begin n_err++; $display("FAIL b2b_cs_gap: got %0d want 3", m_cs_high_tail); end
    monitor_frame(1);
    n_cmp++; if (m_word !== 32'h0000FFFF) begin n_err++; $display("FAIL b2b_word1: got %h want 0000ffff", m_word); end
    n_cmp++; if (m_done != 1) begin n_err++; $display("FAIL b2b_done1: got %0d want 1", m_done); end
  endtask

  task automatic test_reset_mid_frame();
    int   rises;
    int   done_seen;
    logic prev;
    send(16'h01FF, 32'd1, 1'b0);
    rises = 0; prev = dac_sclk;
    for (int c = 0; c < 200 && rises < 8; c++) begin
      @(posedge clk); #1;
      if (dac_sclk && !prev) rises++;
      prev = dac_sclk;
    end
    n_cmp++; if ({dac_cs, dac_sd} !== 2'b01)
      begin n_err++; $display("FAIL mid_pre_reset: got cs,sd=%b want 01", {dac_cs, dac_sd}); end
    resetn = 1'b0;
    #1;
    n_cmp++; if ({dac_cs, dac_sclk, dac_sd} !== 3'b110)
      begin n_err++; $display("FAIL mid_async_pins: got %b want 110", {dac_cs, dac_sclk, dac_sd}); end
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (dac_done) done_seen++;
    end
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (dac_done) done_seen++;
    end
    n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL mid_no_done: got %0d pulses want 0", done_seen); end
    send(16'h5A3C, 32'd1, 1'b0);
    monitor_frame(1);
    n_cmp++; if (m_word !== 32'h00005A3C) begin n_err++; $display("FAIL mid_next_word: got %h want 00005a3c", m_word); end
    n_cmp++; if (m_done != 1) begin n_err++; $display("FAIL mid_next_done: got %0d want 1", m_done); end
  endtask

  task automatic test_inversion();
    send(16'h8000, 32'd1, 1'b0);
    monitor_frame(1);
    n_cmp++; if (m_inv_err != 0) begin n_err++; $display("FAIL inv_waveform: got %0d differing cycles want 0", m_inv_err); end
    n_cmp++; if (m_word !== 32'h00008000) begin n_err++; $display("FAIL inv_word: got %h want 00008000", m_word); end
  endtask

  task automatic test_ldac();
`ifdef DAC_SERTX_LDAC_EN
    send(16'h1234, 32'd2, 1'b0);
    monitor_frame(2);
    n_cmp++; if (m_ldac_low != 2) begin n_err++; $display("FAIL ldac_width: got %0d want 2", m_ldac_low); end
    n_cmp++; if (m_ldac_first - m_cs_rise != 2)
      begin n_err++; $display("FAIL ldac_offset: got %0d want 2", m_ldac_first - m_cs_rise); end
    n_cmp++; if (m_ready_at != 72) begin n_err++; $display("FAIL ldac_ready_at: got %0d want 72", m_ready_at); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_divider();
    test_back_to_back();
    test_reset_mid_frame();
    test_inversion();
    test_ldac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
